// File: rtl/mem_wb_stage.sv
// MEM stage: drives word loads/stores to a variable-latency data memory, stalls upstream while an access waits, registers MEM/WB state.
// Optional MISALIGN_TRAP_EN: a misaligned memop is trapped (no request, dmem_err pulse); otherwise addresses are word-aligned.
module mem_wb_stage #(
  parameter int XLEN         = 32,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RegWriteM,
  input  logic            MemWriteM,
  input  logic [1:0]      ResultSrcM,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [XLEN-1:0] PCPlus4M,
  input  logic [4:0]      RdM,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            StallM,
  output logic            dmem_err,
  output logic            RegWriteW,
  output logic [1:0]      ResultSrcW,
  output logic [XLEN-1:0] ALUResultW,
  output logic [XLEN-1:0] ReadDataW,
  output logic [XLEN-1:0] PCPlus4W,
  output logic [4:0]      RdW
);

  localparam int            CW         = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT + 1);
  localparam int            TO_LAST_I  = (WAIT_TIMEOUT == 0) ? 0 : WAIT_TIMEOUT - 1;
  localparam logic [CW-1:0] TO_LAST    = CW'(TO_LAST_I);
  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam bit            TIMEOUT_EN = (WAIT_TIMEOUT != 0);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;

  logic              h_we;
  logic [XLEN-1:0]   h_addr;
  logic [XLEN-1:0]   h_wdata;
  logic              h_regwrite;
  logic [1:0]        h_resultsrc;
  logic [XLEN-1:0]   h_alu;
  logic [XLEN-1:0]   h_pc4;
  logic [4:0]        h_rd;

  logic              memop;
  logic              misalign;
  logic              issue;
  logic              timeout_hit;
  logic [XLEN-1:0]   m_addr;

  assign memop = MemWriteM | (ResultSrcM == 2'b01);

`ifdef MISALIGN_TRAP_EN
  assign misalign = memop & (ALUResultM[1:0] != 2'b00);
  assign m_addr   = ALUResultM;
`else
  assign misalign = 1'b0;
  assign m_addr   = {ALUResultM[XLEN-1:2], 2'b00};
`endif

  assign issue       = memop & ~misalign;
  assign timeout_hit = TIMEOUT_EN && (cnt == TO_LAST) && !dmem_ready;

  // Request and stall are gated by reset so an in-flight access is dropped at once.
  always_comb begin
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = m_addr;
    dmem_wdata = WriteDataM;
    StallM     = 1'b0;
    if (!reset) begin
      if (state == S_WAIT) begin
        dmem_req   = 1'b1;
        dmem_we    = h_we;
        dmem_addr  = h_addr;
        dmem_wdata = h_wdata;
        StallM     = ~dmem_ready;
      end else if (issue) begin
        dmem_req = 1'b1;
        dmem_we  = MemWriteM;
        StallM   = ~dmem_ready;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      h_we        <= 1'b0;
      h_addr      <= '0;
      h_wdata     <= '0;
      h_regwrite  <= 1'b0;
      h_resultsrc <= 2'b00;
      h_alu       <= '0;
      h_pc4       <= '0;
      h_rd        <= '0;
      dmem_err    <= 1'b0;
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 2'b00;
      ALUResultW  <= '0;
      ReadDataW   <= '0;
      PCPlus4W    <= '0;
      RdW         <= '0;
    end else begin
      dmem_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (issue && !dmem_ready) begin
            h_we        <= MemWriteM;
            h_addr      <= m_addr;
            h_wdata     <= WriteDataM;
            h_regwrite  <= RegWriteM;
            h_resultsrc <= ResultSrcM;
            h_alu       <= ALUResultM;
            h_pc4       <= PCPlus4M;
            h_rd        <= RdM;
            cnt         <= '0;
            RegWriteW   <= 1'b0;
            state       <= S_WAIT;
          end else begin
            // A trapped misaligned access still flows to WB, but never writes a register.
            RegWriteW  <= RegWriteM & ~misalign;
            ResultSrcW <= ResultSrcM;
            ALUResultW <= ALUResultM;
            PCPlus4W   <= PCPlus4M;
            RdW        <= RdM;
            if (issue && !MemWriteM)
              ReadDataW <= dmem_rdata;
            if (misalign)
              dmem_err <= 1'b1;
          end
        end
        S_WAIT: begin
          if (dmem_ready) begin
            RegWriteW  <= h_regwrite;
            ResultSrcW <= h_resultsrc;
            ALUResultW <= h_alu;
            PCPlus4W   <= h_pc4;
            RdW        <= h_rd;
            if (!h_we)
              ReadDataW <= dmem_rdata;
            state <= S_IDLE;
          end else begin
            RegWriteW <= 1'b0;
            if (cnt != CNT_MAX)
              cnt <= cnt + 1'b1;
            if (timeout_hit) begin
              dmem_err <= 1'b1;
              state    <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage: a bench-side memory holds ready low for a planned number of cycles,
// a reference model predicts each WB update into a queue, and a monitor pops it whenever the stage advances.
module tb_mem_wb_stage;

  localparam int XLEN = 32;
  localparam int TO   = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            RegWriteM, MemWriteM;
  logic [1:0]      ResultSrcM;
  logic [XLEN-1:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]      RdM;
  logic            dmem_req, dmem_we;
  logic [XLEN-1:0] dmem_addr, dmem_wdata;
  logic            dmem_ready;
  logic [XLEN-1:0] dmem_rdata;
  logic            StallM, dmem_err;
  logic            RegWriteW;
  logic [1:0]      ResultSrcW;
  logic [XLEN-1:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]      RdW;

  mem_wb_stage #(.XLEN(XLEN), .WAIT_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .StallM(StallM), .dmem_err(dmem_err),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
    .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .RdW(RdW)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic        we;
    logic [1:0]  rs;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
    logic [4:0]  rd;
  } instr_t;

  typedef struct {
    logic        rw;
    logic [1:0]  rs;
    logic [31:0] alu;
    logic [31:0] rdat;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic        err;
  } wb_t;

  wb_t exp_q[$];
  wb_t model;
  int  errors = 0;
  int  checks = 0;
  bit  mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    model.rw = 1'b0; model.rs = 2'b00; model.alu = '0; model.rdat = '0;
    model.pc4 = '0; model.rd = '0; model.err = 1'b0;
  endtask

  // Monitor: the stage hands an instruction to WB on every edge where StallM was low, or on a timeout abort.
  initial begin : monitor
    logic stall_pre;
    wb_t  e;
    forever begin
      @(negedge clk);
      #2 stall_pre = StallM;
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (!stall_pre || dmem_err) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wb_unexpected: WB update with empty queue at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            chk("RegWriteW",  32'(RegWriteW),  32'(e.rw));
            chk("ResultSrcW", 32'(ResultSrcW), 32'(e.rs));
            chk("ALUResultW", ALUResultW,      e.alu);
            chk("ReadDataW",  ReadDataW,       e.rdat);
            chk("PCPlus4W",   PCPlus4W,        e.pc4);
            chk("RdW",        32'(RdW),        32'(e.rd));
            chk("dmem_err",   32'(dmem_err),   32'(e.err));
          end
        end else begin
          chk("stall_bubble_RegWriteW", 32'(RegWriteW), 32'd0);
          chk("stall_no_err",           32'(dmem_err),  32'd0);
        end
      end
    end
  end

  // Runs one instruction; n = number of cycles the memory holds ready low before completing.
  task automatic run(input instr_t i, input int n);
    logic        memop, mis, issue, is_load;
    logic [31:0] rdv, a_exp;
    int          cyc;
    wb_t         e;
    memop   = i.we | (i.rs == 2'b01);
    is_load = memop & ~i.we;
`ifdef MISALIGN_TRAP_EN
    mis   = memop && (i.alu[1:0] != 2'b00);
    a_exp = i.alu;
`else
    mis   = 1'b0;
    a_exp = {i.alu[31:2], 2'b00};
`endif
    issue = memop & ~mis;
    rdv   = $urandom;

    if (issue && n > TO) begin
      model.rw  = 1'b0;
      model.err = 1'b1;
    end else begin
      model.rw  = i.rw & ~mis;
      model.rs  = i.rs;
      model.alu = i.alu;
      model.pc4 = i.pc4;
      model.rd  = i.rd;
      model.err = mis;
      if (issue && is_load) model.rdat = rdv;
    end
    e = model;
    exp_q.push_back(e);

    cyc = !issue ? 1 : ((n > TO) ? TO + 1 : n + 1);
    RegWriteM  = i.rw;
    MemWriteM  = i.we;
    ResultSrcM = i.rs;
    ALUResultM = i.alu;
    WriteDataM = i.wd;
    PCPlus4M   = i.pc4;
    RdM        = i.rd;
    for (int c = 0; c < cyc; c++) begin
      dmem_ready = issue ? (c == n) : 1'($urandom_range(0, 1));
      dmem_rdata = (c == n) ? rdv : $urandom;
      #2;
      chk("dmem_req", 32'(dmem_req), 32'(issue));
      chk("StallM",   32'(StallM),   32'(issue && (c < n)));
      if (issue) begin
        chk("dmem_addr",  dmem_addr,      a_exp);
        chk("dmem_we",    32'(dmem_we),   32'(i.we));
        chk("dmem_wdata", dmem_wdata,     i.wd);
      end
      @(negedge clk);
    end
  endtask

  function automatic instr_t mk(input logic rw, input logic we, input logic [1:0] rs,
                                input logic [31:0] alu, input logic [31:0] wd,
                                input logic [31:0] pc4, input logic [4:0] rd);
    instr_t t;
    t.rw = rw; t.we = we; t.rs = rs; t.alu = alu; t.wd = wd; t.pc4 = pc4; t.rd = rd;
    return t;
  endfunction

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    instr_t r;
    int     n;
    reset = 1'b1;
    RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0; ALUResultM = 0;
    WriteDataM = 0; PCPlus4M = 0; RdM = 0; dmem_ready = 0; dmem_rdata = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_RegWriteW", 32'(RegWriteW), 32'd0);
    chk("rst_ALUResultW", ALUResultW, 32'd0);
    chk("rst_err", 32'(dmem_err), 32'd0);
    reset = 1'b0;

    // Reset while a load is waiting: everything drops immediately.
    RegWriteM = 1; ALUResultM = 32'hABCD; RdM = 5'd7; PCPlus4M = 32'h44;
    @(negedge clk);
    ResultSrcM = 2'b01; ALUResultM = 32'h300; dmem_ready = 0;
    repeat (3) @(negedge clk);
    #2 chk("wait_req_before_reset", 32'(dmem_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_req",    32'(dmem_req),   32'd0);
    chk("midrst_stall",  32'(StallM),     32'd0);
    chk("midrst_RdW",    32'(RdW),        32'd0);
    chk("midrst_PC4W",   PCPlus4W,        32'd0);
    chk("midrst_ALUW",   ALUResultW,      32'd0);
    chk("midrst_RSW",    32'(ResultSrcW), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    mon_en = 1'b1;

    run(mk(1, 0, 2'b01, 32'h0000_0500, 32'h0, 32'h8, 5'd9), 1);
    run(mk(1, 0, 2'b00, 32'h0000_1234, 32'h5555, 32'h10, 5'd5), 0);
    run(mk(1, 0, 2'b01, 32'h0000_0100, 32'h0, 32'h14, 5'd6), 0);
    run(mk(0, 1, 2'b00, 32'h0000_0200, 32'hCAFE_F00D, 32'h18, 5'd0), 3);
    run(mk(1, 0, 2'b01, 32'h0000_0400, 32'h0, 32'h1C, 5'd3), 9);
    run(mk(0, 0, 2'b00, 32'h0000_0000, 32'h0, 32'h20, 5'd0), 0);
    run(mk(1, 0, 2'b01, 32'h0000_0102, 32'h0, 32'h24, 5'd8), 1);
    run(mk(1, 0, 2'b10, 32'h0000_0777, 32'h0, 32'h28, 5'd4), 0);
    run(mk(1, 0, 2'b01, 32'h0000_0600, 32'h0, 32'h2C, 5'd2), TO);
    run(mk(1, 1, 2'b01, 32'h0000_0604, 32'h1357_9BDF, 32'h30, 5'd1), 2);

    for (int k = 0; k < 300; k++) begin
      r.rw  = 1'($urandom_range(0, 1));
      r.we  = ($urandom_range(0, 3) == 0);
      r.rs  = 2'($urandom_range(0, 3));
      r.alu = $urandom;
      r.wd  = $urandom;
      r.pc4 = $urandom;
      r.rd  = 5'($urandom_range(0, 31));
      n     = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, TO + 2);
      run(r, n);
    end

    mon_en = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d expected WB updates never seen, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
MEM-stage consumer of the EX/MEM pipeline register outputs. Issues word loads/stores to a variable-latency data memory over a req/ready handshake. Stalls the upstream pipeline while an access is outstanding. Registers the MEM/WB pipeline state for the writeback stage.

Parameters:
XLEN, 32, data/address width.
WAIT_TIMEOUT, 255, maximum WAIT cycles before abort; 0 disables the timeout.

Ports:
clk  input  1  clock
reset  input  1  async active-high reset
RegWriteM  input  1  register write enable from EX/MEM
MemWriteM  input  1  store enable from EX/MEM
ResultSrcM  input  2  result select; 2'b01 = load
ALUResultM  input  XLEN  memory address / ALU result
WriteDataM  input  XLEN  store data
PCPlus4M  input  XLEN  PC+4
RdM  input  5  destination register
dmem_req  output  1  memory request
dmem_we  output  1  1 = store, 0 = load
dmem_addr  output  XLEN  memory address
dmem_wdata  output  XLEN  store data
dmem_ready  input  1  memory completes the access this cycle
dmem_rdata  input  XLEN  load data, valid when dmem_ready=1
StallM  output  1  hold EX/MEM and all earlier stages
dmem_err  output  1  one-cycle pulse on timeout abort
RegWriteW  output  1  WB register write enable
ResultSrcW  output  2  WB result select
ALUResultW  output  XLEN  WB ALU result
ReadDataW  output  XLEN  WB load data
PCPlus4W  output  XLEN  WB PC+4
RdW  output  5  WB destination register

Behaviour:
- Reset: clk is the clock; reset is asynchronous, active-high.
  - FSM goes to IDLE; timeout counter cleared.
  - All W outputs go to 0; dmem_err goes to 0.
  - dmem_req, dmem_we and StallM go to 0 immediately, including when reset hits mid-access (the access is abandoned).
- Memory op: memop = MemWriteM | (ResultSrcM==2'b01). A store takes priority if both are set.
- IDLE, memop=0:
  - No request; StallM=0.
  - At the next edge, W registers load the M inputs; ReadDataW holds its previous value.
- IDLE, memop=1:
  - Combinationally drive dmem_req=1, dmem_we=MemWriteM, dmem_addr=ALUResultM, dmem_wdata=WriteDataM.
  - If dmem_ready=1 (zero-wait): StallM=0; at the edge, W loads the M inputs and ReadDataW<=dmem_rdata (loads only). Stay IDLE.
  - If dmem_ready=0: StallM=1. At the edge, capture addr/we/wdata plus RdM, RegWriteM, ResultSrcM, ALUResultM, PCPlus4M into internal holding registers. Enter WAIT, clear the counter, and bubble WB (RegWriteW<=0).
- WAIT:
  - dmem_req=1; address, we and wdata come from the holding registers and stay stable until ready.
  - StallM = ~dmem_ready.
  - dmem_ready=1: at the edge, W loads from the holding registers, ReadDataW<=dmem_rdata (load only), return to IDLE. Upstream advances on that same edge.
  - dmem_ready=0: counter increments; WB receives a bubble (RegWriteW<=0, other W fields unchanged).
  - Timeout: when WAIT_TIMEOUT != 0 and counter == WAIT_TIMEOUT-1 with dmem_ready=0:
    - dmem_req drops next cycle; FSM returns to IDLE.
    - dmem_err pulses high for exactly one cycle.
    - WB receives a bubble; the instruction is discarded, with no register write.
- Latency: one cycle M->W for non-memory ops and zero-wait accesses. For an access, N+1 cycles, where N = cycles with ready low.
- A store never writes back unless RegWriteM is set; W fields are propagated unchanged.
- dmem_ready while dmem_req=0 is ignored.
- The counter saturates; it never wraps.

Optional Feature:
MISALIGN_TRAP_EN.
- Defined:
  - A memop with ALUResultM[1:0]!=0 issues no request and stalls for 0 cycles.
  - dmem_err pulses for one cycle.
  - WB receives the instruction with RegWriteW forced to 0.
- Undefined: dmem_addr[1:0] is forced to 2'b00 on every access (word-aligned); no error is raised.

Test Plan:
- Reset mid-WAIT: assert reset while a load is waiting -> dmem_req=0 and StallM=0 immediately; all W outputs 0; the first memop after release issues a fresh request.
- ALU op with RegWriteM=1, ALUResultM=0x1234, RdM=5 -> next cycle RegWriteW=1, ALUResultW=0x1234, RdW=5; dmem_req never asserts.
- Zero-wait load: addr 0x100, ready=1 same cycle, rdata=0xDEADBEEF -> StallM stays 0; next cycle ReadDataW=0xDEADBEEF, ResultSrcW=01.
- 3-wait store: addr 0x200, data 0xCAFEF00D, ready low 3 cycles:
  - StallM high for 3 cycles; addr/wdata stable throughout.
  - RegWriteW=0 during the stall.
  - Writeback follows ready.
- Timeout with WAIT_TIMEOUT=4 and ready held low -> after 4 WAIT cycles, req drops, dmem_err pulses once, no writeback, StallM falls.
- With MISALIGN_TRAP_EN: load at 0x102 -> no req, dmem_err pulse, RegWriteW=0. Without it: req issued at 0x100.
